mp_add_seq: RTL and testbench

Multi-precision sequential adder front-end. Accepts W-bit operands (W = N*CHUNKS) over a valid/ready handshake and adds them N bits per cycle, least-significant chunk first. Each cycle uses one N-bit combinational add of a chunk pair plus the carry registered from the previous chunk. Returns a W+1-bit result (carry-out as MSB) over a valid/ready output handshake. Used wherever operands are wider than the datapath adder.

---
 rtl/mp_add_seq_if.sv | 28 ++
 rtl/mp_add_seq.sv | 133 +++++++++++++
 tb/tb_mp_add_seq.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mp_add_seq_if.sv
// Handshake bundle for mp_add_seq: operand request channel and result channel.
interface mp_add_seq_if #(
  parameter int N      = 32,
  parameter int CHUNKS = 4
);
  localparam int W = N * CHUNKS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   sum;
  logic         busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, busy
  );
endinterface

// File: rtl/mp_add_seq.sv
// Multi-precision sequential adder: N bits per cycle, LS chunk first, W+1-bit result.
// Optional subtract support is enabled by defining MPADD_SUB_EN.
module mp_add_seq #(
  parameter int N      = 32,
  parameter int CHUNKS = 4
) (
  input logic         clk,
  input logic         rst,
  mp_add_seq_if.slave bus
);
  localparam int W     = N * CHUNKS;
  localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W:0]       sum_q, sum_d;
  logic             in_ready_q, out_valid_q, busy_q;

  logic [N-1:0]     chunk_a_s, chunk_b_s;
  logic [N:0]       chunk_add_s;
  logic [W-1:0]     b_cap_s;
  logic             carry_cap_s;

`ifdef MPADD_SUB_EN
  // Subtraction is a + ~b + 1, so only the captured B and the seed carry change.
  always_comb begin
    if (bus.sub) begin
      b_cap_s     = ~bus.b;
      carry_cap_s = 1'b1;
    end else begin
      b_cap_s     = bus.b;
      carry_cap_s = bus.cin;
    end
  end
`else
  logic sub_unused_s;
  assign sub_unused_s = bus.sub;

  always_comb begin
    b_cap_s     = bus.b;
    carry_cap_s = bus.cin;
  end
`endif

  always_comb begin
    chunk_a_s   = a_q[idx_q*N +: N];
    chunk_b_s   = b_q[idx_q*N +: N];
    chunk_add_s = {1'b0, chunk_a_s} + {1'b0, chunk_b_s} + {{N{1'b0}}, carry_q};
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = b_cap_s;
          carry_d = carry_cap_s;
          idx_d   = {IDX_W{1'b0}};
          sum_d   = {(W+1){1'b0}};
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sum_d[idx_q*N +: N] = chunk_add_s[N-1:0];
        carry_d             = chunk_add_s[N];
        if (idx_q == LAST_IDX) begin
          sum_d[W] = chunk_add_s[N];
          state_d  = S_DONE;
        end else begin
          idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= {IDX_W{1'b0}};
      carry_q     <= 1'b0;
      a_q         <= {W{1'b0}};
      b_q         <= {W{1'b0}};
      sum_q       <= {(W+1){1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sum       = sum_q;
endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq: directed boundary cases plus random operands
// compared against a plain-arithmetic reference model.
module tb_mp_add_seq;
  localparam int N      = 32;
  localparam int CHUNKS = 4;
  localparam int W      = N * CHUNKS;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  mp_add_seq_if #(.N(N), .CHUNKS(CHUNKS)) bus ();

  mp_add_seq #(.N(N), .CHUNKS(CHUNKS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] rnd_w();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: exact sum over W+1 bits; subtract gives difference plus no-borrow flag.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W:0] r;
    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
`ifdef MPADD_SUB_EN
    if (sub) begin
      r[W-1:0] = a - b;
      r[W]     = (a >= b);
    end
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one transaction and wait (bounded) until the result is presented.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
    int lat;
    chk("in_ready_idle", {{W{1'b0}}, bus.in_ready}, {{W{1'b0}}, 1'b1});
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
    tick();
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 50) begin
      chk("busy_run", {{W{1'b0}}, bus.busy}, {{W{1'b0}}, 1'b1});
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.a        = rnd_w();
      bus.b        = rnd_w();
      bus.cin      = 1'($urandom_range(0, 1));
      bus.sub      = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    bus.in_valid = 1'b0;
    chk("latency", (W+1)'(lat), (W+1)'(CHUNKS));
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("drain_out_valid", {{W{1'b0}}, bus.out_valid}, {(W+1){1'b0}});
    chk("drain_in_ready", {{W{1'b0}}, bus.in_ready}, {{W{1'b0}}, 1'b1});
    chk("drain_busy", {{W{1'b0}}, bus.busy}, {(W+1){1'b0}});
  endtask

  task automatic txn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic cin, input logic sub);
    launch(a, b, cin, sub);
    chk(tag, bus.sum, ref_sum(a, b, cin, sub));
    drain();
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] ra, rb;
    logic [W:0]   held;
    logic         rc, rs;
    n_vec         = 0;
    n_err         = 0;
    ones          = '1;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = {W{1'b0}};
    bus.b         = {W{1'b0}};
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_in_ready", {{W{1'b0}}, bus.in_ready}, {{W{1'b0}}, 1'b1});
    chk("rst_out_valid", {{W{1'b0}}, bus.out_valid}, {(W+1){1'b0}});
    chk("rst_busy", {{W{1'b0}}, bus.busy}, {(W+1){1'b0}});
    chk("rst_sum", bus.sum, {(W+1){1'b0}});

    launch(128'd1, 128'd1, 1'b0, 1'b0);
    chk("one_plus_one", bus.sum, 129'd2);
    chk("done_busy", {{W{1'b0}}, bus.busy}, {{W{1'b0}}, 1'b1});
    drain();

    txn("all_ones_ripple", ones, 128'd0, 1'b1, 1'b0);
    chk("ripple_const", ref_sum(ones, 128'd0, 1'b1, 1'b0), {1'b1, {W{1'b0}}});
    txn("chunk0_carry", 128'h0000_0000_FFFF_FFFF, 128'd0, 1'b1, 1'b0);
    txn("small_add", 128'h1234, 128'h4321, 1'b0, 1'b0);
    txn("ones_plus_ones", ones, ones, 1'b1, 1'b0);

    // Backpressure: result and flags must hold while in_valid and operands churn.
    launch(rnd_w(), rnd_w(), 1'b1, 1'b0);
    held = bus.sum;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.a        = rnd_w();
      bus.b        = rnd_w();
      tick();
      chk("bp_sum", bus.sum, held);
      chk("bp_in_ready", {{W{1'b0}}, bus.in_ready}, {(W+1){1'b0}});
      chk("bp_out_valid", {{W{1'b0}}, bus.out_valid}, {{W{1'b0}}, 1'b1});
    end
    drain();

    // Reset in the middle of RUN discards the transaction.
    bus.in_valid = 1'b1;
    bus.a        = rnd_w();
    bus.b        = rnd_w();
    bus.cin      = 1'b0;
    bus.sub      = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", {{W{1'b0}}, bus.in_ready}, {{W{1'b0}}, 1'b1});
    chk("midrst_out_valid", {{W{1'b0}}, bus.out_valid}, {(W+1){1'b0}});
    chk("midrst_sum", bus.sum, {(W+1){1'b0}});
    tick();
    chk("midrst_stays_idle", {{W{1'b0}}, bus.out_valid}, {(W+1){1'b0}});
    txn("after_rst", 128'd10, 128'd20, 1'b0, 1'b0);
    chk("after_rst_const", ref_sum(128'd10, 128'd20, 1'b0, 1'b0), 129'd30);

    txn("sub_7_5", 128'd7, 128'd5, 1'b0, 1'b1);
    txn("sub_5_7", 128'd5, 128'd7, 1'b0, 1'b1);
    txn("sub_eq", 128'd99, 128'd99, 1'b1, 1'b1);

    for (int i = 0; i < 20; i++) begin
      ra = rnd_w();
      rb = rnd_w();
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      txn("random", ra, rb, rc, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
